// File: rtl/clock_time_ctrl.sv
// Time-of-day controller: BCD seconds/minutes/hours chain driven by a 1 Hz tick,
// plus the button-driven time-setting state machine and blink phase.
module clock_time_ctrl #(
    parameter int HOURS     = 24,
    parameter int INIT_HOUR = 0,
    parameter int INIT_MIN  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic [3:0] hour_ones,
    output logic [3:0] hour_tens,
    output logic [1:0] sel,
    output logic       blink,
    output logic       day_pulse
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2,
        SET_S = 2'd3
    } state_t;

    localparam logic [3:0] HMAX_T = 4'((HOURS - 1) / 10);
    localparam logic [3:0] HMAX_O = 4'((HOURS - 1) % 10);
    localparam logic [3:0] IH_T   = 4'(INIT_HOUR / 10);
    localparam logic [3:0] IH_O   = 4'(INIT_HOUR % 10);
    localparam logic [3:0] IM_T   = 4'(INIT_MIN / 10);
    localparam logic [3:0] IM_O   = 4'(INIT_MIN % 10);

    state_t     state;
    logic [7:0] sec;   // {tens, ones}
    logic [7:0] min;
    logic [7:0] hour;
    logic       sec_wrap;
    logic       min_wrap;
    logic       hour_wrap;

    function automatic logic [7:0] inc60(input logic [7:0] v);
        if (v[3:0] == 4'd9) begin
            if (v[7:4] == 4'd5)
                return 8'h00;
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] inc_hour(input logic [7:0] v);
        if (v == {HMAX_T, HMAX_O})
            return 8'h00;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign sec_wrap  = (sec == 8'h59);
    assign min_wrap  = (min == 8'h59);
    assign hour_wrap = (hour == {HMAX_T, HMAX_O});

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            sec       <= '0;
            min       <= {IM_T, IM_O};
            hour      <= {IH_T, IH_O};
            blink     <= 1'b0;
            day_pulse <= 1'b0;
        end else begin
            day_pulse <= 1'b0;
            if (state == RUN) begin
                blink <= 1'b0;
                if (tick) begin
                    sec <= inc60(sec);
                    if (sec_wrap) begin
                        min <= inc60(min);
                        if (min_wrap) begin
                            hour      <= inc_hour(hour);
                            day_pulse <= hour_wrap;
                        end
                    end
                end
                if (btn_mode)
                    state <= SET_H;
            end else if (btn_mode) begin
                // 2-bit increment wraps SET_S back to RUN; mode discards btn_inc and tick
                state <= state_t'(state + 2'd1);
                blink <= 1'b0;
            end else begin
                if (tick)
                    blink <= ~blink;
                if (btn_inc) begin
                    case (state)
                        SET_H:   hour <= inc_hour(hour);
                        SET_M:   min  <= inc60(min);
                        default: sec  <= inc60(sec);
                    endcase
                end
            end
        end
    end

    assign sec_ones  = sec[3:0];
    assign sec_tens  = sec[7:4];
    assign min_ones  = min[3:0];
    assign min_tens  = min[7:4];
    assign hour_ones = hour[3:0];
    assign hour_tens = hour[7:4];
    assign sel       = state;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Bench for clock_time_ctrl: a 24-hour and a 12-hour instance checked every cycle
// against a seconds-of-day reference model, with directed scenarios then random stimulus.
module tb_clock_time_ctrl;

    logic       clk = 1'b0;
    logic [1:0] tick_v, mode_v, inc_v, rst_v;
    logic [3:0] so [2], st [2], mo [2], mt [2], ho [2], ht [2];
    logic [1:0] sel_o [2];
    logic       blink_o [2];
    logic       day_o [2];

    int checks = 0;
    int errors = 0;

    localparam int HRS [2] = '{24, 12};
    localparam int IH  [2] = '{0, 3};
    localparam int IM  [2] = '{0, 45};

    // reference model state: plain integers, mode 0=RUN 1=hour 2=min 3=sec
    int mh [2], mm [2], ms [2], mst [2], mbl [2], mday [2];

    always #5 clk = ~clk;

    clock_time_ctrl #(.HOURS(24), .INIT_HOUR(0), .INIT_MIN(0)) dut_a (
        .clk(clk), .rst(rst_v[0]), .tick(tick_v[0]), .btn_mode(mode_v[0]), .btn_inc(inc_v[0]),
        .sec_ones(so[0]), .sec_tens(st[0]), .min_ones(mo[0]), .min_tens(mt[0]),
        .hour_ones(ho[0]), .hour_tens(ht[0]), .sel(sel_o[0]), .blink(blink_o[0]),
        .day_pulse(day_o[0])
    );

    clock_time_ctrl #(.HOURS(12), .INIT_HOUR(3), .INIT_MIN(45)) dut_b (
        .clk(clk), .rst(rst_v[1]), .tick(tick_v[1]), .btn_mode(mode_v[1]), .btn_inc(inc_v[1]),
        .sec_ones(so[1]), .sec_tens(st[1]), .min_ones(mo[1]), .min_tens(mt[1]),
        .hour_ones(ho[1]), .hour_tens(ht[1]), .sel(sel_o[1]), .blink(blink_o[1]),
        .day_pulse(day_o[1])
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int bcd6(input int h, input int m, input int s);
        return ((h / 10) << 20) | ((h % 10) << 16) | ((m / 10) << 12) |
               ((m % 10) << 8) | ((s / 10) << 4) | (s % 10);
    endfunction

    function automatic int obs_time(input int d);
        return int'({ht[d], ho[d], mt[d], mo[d], st[d], so[d]});
    endfunction

    task automatic model_edge(input int d);
        int total;
        if (rst_v[d]) begin
            mst[d] = 0; ms[d] = 0; mm[d] = IM[d]; mh[d] = IH[d]; mbl[d] = 0; mday[d] = 0;
            return;
        end
        mday[d] = 0;
        if (mst[d] == 0 && tick_v[d]) begin
            total = mh[d] * 3600 + mm[d] * 60 + ms[d] + 1;
            if (total == HRS[d] * 3600) begin
                total   = 0;
                mday[d] = 1;
            end
            mh[d] = total / 3600;
            mm[d] = (total / 60) % 60;
            ms[d] = total % 60;
        end
        if (mode_v[d]) begin
            mst[d] = (mst[d] + 1) % 4;
            mbl[d] = 0;
        end else if (mst[d] == 0) begin
            mbl[d] = 0;
        end else begin
            if (tick_v[d]) mbl[d] = 1 - mbl[d];
            if (inc_v[d]) begin
                case (mst[d])
                    1:       mh[d] = (mh[d] + 1) % HRS[d];
                    2:       mm[d] = (mm[d] + 1) % 60;
                    default: ms[d] = (ms[d] + 1) % 60;
                endcase
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        for (int d = 0; d < 2; d++) model_edge(d);
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("time%0d", d), obs_time(d), bcd6(mh[d], mm[d], ms[d]));
            check($sformatf("sel%0d", d), int'(sel_o[d]), mst[d]);
            check($sformatf("blink%0d", d), int'(blink_o[d]), mbl[d]);
            check($sformatf("day%0d", d), int'(day_o[d]), mday[d]);
        end
    endtask

    task automatic cyc(input int d, input logic t, input logic m, input logic i, input logic r);
        tick_v = '0; mode_v = '0; inc_v = '0; rst_v = '0;
        tick_v[d] = t; mode_v[d] = m; inc_v[d] = i; rst_v[d] = r;
        step();
    endtask

    // walk RUN -> SET_H -> SET_M -> SET_S -> RUN loading h:m:s
    task automatic set_time(input int d, input int h, input int m, input int s);
        cyc(d, 0, 1, 0, 0);
        while (mh[d] != h) cyc(d, 0, 0, 1, 0);
        cyc(d, 0, 1, 0, 0);
        while (mm[d] != m) cyc(d, 0, 0, 1, 0);
        cyc(d, 0, 1, 0, 0);
        while (ms[d] != s) cyc(d, 0, 0, 1, 0);
        cyc(d, 0, 1, 0, 0);
    endtask

    initial begin
        tick_v = '0; mode_v = '0; inc_v = '0; rst_v = '1;
        for (int d = 0; d < 2; d++) begin
            mh[d] = 0; mm[d] = 0; ms[d] = 0; mst[d] = 0; mbl[d] = 0; mday[d] = 0;
        end
        #2;
        step();
        check("reset_b_time", obs_time(1), 32'h034500);

        for (int n = 0; n < 61; n++) cyc(0, 1, 0, 0, 0);
        check("run61_time", obs_time(0), 32'h000101);

        set_time(0, 23, 59, 59);
        cyc(0, 1, 0, 0, 0);
        check("rollover_day", int'(day_o[0]), 1);
        cyc(0, 0, 0, 0, 0);

        cyc(0, 0, 1, 0, 0);
        for (int n = 0; n < 25; n++) cyc(0, 0, 0, 1, 0);
        check("hour_inc25", int'({ht[0], ho[0]}), 32'h01);
        cyc(0, 0, 1, 0, 0);
        while (mm[0] != 59) cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        for (int n = 0; n < 10; n++) cyc(0, 1, 0, 0, 0);
        check("frozen_time", obs_time(0), 32'h010000);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        while (mh[0] != 5) cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 1, 1, 0);
        check("mode_inc_hour", int'({ht[0], ho[0]}), 32'h05);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);

        cyc(0, 0, 0, 0, 1);
        set_time(0, 0, 0, 9);
        cyc(0, 1, 1, 0, 0);
        check("tick_mode_time", obs_time(0), 32'h000010);
        cyc(0, 0, 0, 0, 1);

        set_time(1, 11, 59, 59);
        cyc(1, 1, 0, 0, 0);
        check("b_rollover", obs_time(1), 32'h000000);
        for (int n = 0; n < 3; n++) cyc(1, 0, 1, 0, 0);
        cyc(1, 1, 0, 1, 0);
        cyc(1, 1, 1, 1, 1);
        check("b_rst_time", obs_time(1), 32'h034500);

        for (int n = 0; n < 6000; n++) begin
            for (int d = 0; d < 2; d++) begin
                tick_v[d] = ($urandom_range(0, 2) == 0);
                mode_v[d] = ($urandom_range(0, 9) == 0);
                inc_v[d]  = ($urandom_range(0, 2) == 0);
                rst_v[d]  = ($urandom_range(0, 299) == 0);
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clock_time_ctrl.md
Name: clock_time_ctrl

Overview:
Time-of-day controller for the digital clock. It sequences the BCD seconds/minutes/hours digit chain from a 1 Hz tick. It also owns the user time-setting state machine, driven by two debounced button pulses. Its outputs feed the display mux and the blink logic directly.

Parameters:
HOURS, 24, hour modulus; legal values 12 or 24; hours count 0..HOURS-1
INIT_HOUR, 0, hour value loaded at reset, binary, must be < HOURS
INIT_MIN, 0, minute value loaded at reset, 0..59

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
tick  input  1  one-cycle enable, 1 Hz, from prescaler
btn_mode  input  1  one-cycle pulse, advances the setting state
btn_inc  input  1  one-cycle pulse, increments the selected field
sec_ones  output  4  BCD seconds units
sec_tens  output  4  BCD seconds tens (0..5)
min_ones  output  4  BCD minutes units
min_tens  output  4  BCD minutes tens (0..5)
hour_ones  output  4  BCD hours units
hour_tens  output  4  BCD hours tens
sel  output  2  field being set: 0 none/RUN, 1 hour, 2 min, 3 sec
blink  output  1  blanking phase for the selected field
day_pulse  output  1  one-cycle pulse on rollover to 00:00:00

Behaviour:
- Single clock domain. All outputs are registered. rst is sampled only on rising clk.
- Reset state:
  - FSM = RUN, sel=0, blink=0, day_pulse=0.
  - Seconds = 00. Minutes = INIT_MIN in BCD. Hours = INIT_HOUR in BCD.
- FSM states are RUN, SET_H, SET_M, SET_S. btn_mode advances RUN->SET_H->SET_M->SET_S->RUN. With no btn_mode the FSM holds its state.
- sel encoding: RUN=0, SET_H=1, SET_M=2, SET_S=3.
- Timekeeping in RUN, on tick:
  - sec_ones increments; 9 wraps to 0 and carries into sec_tens.
  - sec_tens 5 with a carry wraps to 0 and carries into minutes. The minute digits follow the same rule.
  - Hours increment on a minute carry. HOURS-1 wraps to 00 and carries out.
  - The hour carry-out (23:59:59->00:00:00 for HOURS=24) asserts day_pulse for exactly one cycle. It is registered together with the digit update.
- Latency: a tick sampled at edge N updates the digits at edge N. The new values are visible in cycle N+1. There is no extra pipeline stage.
- In SET_H, SET_M and SET_S, tick does not advance time. Time is frozen and day_pulse stays 0.
- btn_inc in a SET state increments only the selected field, modulo its range:
  - hour: HOURS-1 -> 0
  - min: 59 -> 0
  - sec: 59 -> 0
  - There is no carry into the next field and no day_pulse.
- btn_inc in RUN is ignored.
- blink:
  - In a SET state, blink toggles on every tick.
  - On entry to any SET state, blink is cleared to 0.
  - In RUN, blink is forced to 0.
- Simultaneous events:
  - btn_mode + btn_inc in the same cycle: mode transition wins, btn_inc is discarded.
  - tick + btn_mode in RUN: time advances AND the state moves to SET_H in the same edge.
  - tick + btn_mode in SET_S: the state returns to RUN. That tick is not applied to time.
  - tick + btn_inc in a SET state: the increment applies, and blink toggles.
- rst asserted mid-operation (any state, any cycle): reset state at the next edge, overriding all other inputs.
- Digit registers never hold a non-BCD or out-of-range value. Arithmetic is per-digit BCD with explicit wrap compares, never binary add-then-convert.

Test Plan:
- Reset release, INIT_HOUR=0, INIT_MIN=0, then 61 ticks in RUN -> time reads 00:01:01, sel=0, blink=0, day_pulse never high.
- Preload via SET (23, 59, 59), return to RUN, one tick -> next cycle reads 00:00:00, day_pulse high exactly one cycle.
- btn_mode once -> sel=1. btn_inc 25 times from hour 00 (HOURS=24) -> hour reads 01. Minutes and seconds unchanged, day_pulse 0.
- In SET_M at minute 59, btn_inc -> minute 00, hour unchanged. 10 ticks in SET_M -> time frozen, blink toggles 10 times ending at 0.
- Same-cycle btn_mode+btn_inc in SET_H with hour 05 -> sel=2, hour still 05. Same-cycle tick+btn_mode in RUN at 00:00:09 -> 00:00:10 and sel=1.
- HOURS=12: from 11:59:59 in RUN, tick -> 00:00:00 with day_pulse. Then assert rst mid-SET_S -> RUN, time = INIT values, blink=0.
